tlp_tx_arbiter: RTL and testbench
=================================

TLP_TX_ARBITER -- requirements
Module: tlp_tx_arbiter

Interface
REQ-001: Parameter NUM_SRC, default 4: number of TLP requesters sharing the PCIe TX stream; legal range 2..8.
REQ-002: Parameter DATA_W, default 256: beat width in bits; fixed at 256.
REQ-003: Port clk, input, 1: the single clock for all logic.
REQ-004: Port reset, input, 1: synchronous, active-high reset.
REQ-005: Port src_data, input, NUM_SRC*256: per-source beat data; source i occupies bits [i*256+255 : i*256].
REQ-006: Port src_empty, input, NUM_SRC*5: per-source empty bytes; source i occupies bits [i*5+4 : i*5].
REQ-007: Port src_startofpacket, input, NUM_SRC: per-source SOP.
REQ-008: Port src_endofpacket, input, NUM_SRC: per-source EOP.
REQ-009: Port src_valid, input, NUM_SRC: per-source valid.
REQ-010: Port src_ready, output, NUM_SRC: per-source ready, with ready latency 0.
REQ-011: Port out_data, output, 256: the arbitrated TLP stream towards the TLP adapter.
REQ-012: Port out_empty, output, 5: empty bytes, copied unchanged from the granted source.
REQ-013: Port out_startofpacket, output, 1: SOP; out_endofpacket, output, 1: EOP.
REQ-014: Port out_channel, output, 8: index of the granted source, zero-extended.
REQ-015: Port out_valid, output, 1; out_ready, input, 1; ready latency 0.
REQ-016: Port busy, output, 1: high while a packet grant is held.
REQ-017: Port drop_count, output, 8: saturating count of discarded orphan beats.

Function
REQ-018: Two-state FSM:
- IDLE: no grant held.
- LOCK: grant held by a single source.
REQ-019: A source i is requesting in IDLE when src_valid[i]=1 and src_startofpacket[i]=1.
REQ-020: Winner selection in IDLE:
- Round-robin search starts at (last_grant+1) mod NUM_SRC, wrapping around.
- The first requesting source found wins.
- On a win: grant and last_grant are registered to the winner's index, and the FSM moves to LOCK on the next edge.
REQ-021: No source is ever accepted in the same cycle it is selected: src_ready is all-zero in IDLE, except for the orphan drops in REQ-027.
REQ-022: In LOCK:
- src_ready[grant] = (!out_valid || out_ready).
- All other src_ready bits are 0.
REQ-023: Accepted beat (src_valid[grant] && src_ready[grant]):
- data, empty, SOP, EOP and channel=grant are registered to the outputs on the next edge, with out_valid=1.
- Latency is exactly 1 cycle.
REQ-024: Output register behaviour:
- The output register holds while out_valid=1 and out_ready=0.
- out_valid drops to 0 after a beat is consumed and no new beat is accepted in that cycle.
REQ-025: Acceptance of a beat with EOP=1 returns the FSM to IDLE on the next edge; the next arbitration occurs in that IDLE cycle, giving a minimum 1-cycle gap between packets.
REQ-026: A single-beat packet (SOP=1 and EOP=1 in the same beat) is legal; the FSM goes LOCK then IDLE after that one beat.
REQ-027: Orphan beats in IDLE:
- A source with src_valid=1 and src_startofpacket=0 gets src_ready=1 for that cycle, and the beat is discarded.
- drop_count increments by the number of such beats, clamped to 255.
- drop_count saturates at 255 and never wraps.
REQ-028: In LOCK, src_startofpacket=1 on a non-first beat is forwarded unchanged; no protocol correction is applied.
REQ-029: src_valid deasserting mid-packet stalls the output; the grant is held indefinitely and no timeout applies.
REQ-030: busy = (state == LOCK).
REQ-031: Data is passed through unmodified; no word reordering and no empty remapping (the adapter downstream performs both).

Reset
REQ-032: While reset=1 at a clock edge, the following are cleared on that edge:
- state=IDLE, last_grant=NUM_SRC-1.
- out_valid=0, out_startofpacket=0, out_endofpacket=0.
- out_data=0, out_empty=0, out_channel=0.
- drop_count=0, busy=0.
- src_ready all 0 (src_ready is combinational from state and out_valid, so it reads 0 during reset).
REQ-033: Reset mid-packet aborts the grant and discards the output register contents; no EOP is synthesised.
REQ-034: After reset release, source 0 has the highest priority for the first arbitration.

Verification
REQ-035: After reset, sources 0 and 2 both present single-beat SOP+EOP with out_ready=1 -> out_channel=0 first, then 2; each beat appears 1 cycle after its src_ready; one idle cycle between packets.
REQ-036: All 4 sources continuously request 3-beat packets for 12 packets -> channel sequence 0,1,2,3 repeated exactly 3 times; SOP and EOP are correctly framed on every packet.
REQ-037: Granted source sends 4 beats while out_ready toggles 1,0,0,1,... -> out_data is held stable while stalled; no beat is lost or duplicated; src_ready=0 in every cycle where out_valid=1 and out_ready=0.
REQ-038: Source 1 drives valid=1, SOP=0 for 300 cycles in IDLE -> drop_count climbs to 255 and stays there; out_valid stays 0.
REQ-039: reset=1 asserted on the 2nd beat of a 4-beat packet -> next cycle out_valid=0, busy=0, drop_count=0; the next arbitration grants source 0 first.
REQ-040: Source 3 sends a packet with empty=5'h14 on its EOP beat -> out_empty=5'h14 and out_channel=8'h03 on that beat.

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
// Round-robin packet arbiter merging NUM_SRC TLP streams onto one PCIe TX stream.
// A grant is locked from SOP to EOP; one output register stage gives 1-cycle latency.
// Beats that arrive without SOP while no grant is held are dropped and counted.
module tlp_tx_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned DATA_W  = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*5-1:0]      src_empty,
   input  logic [NUM_SRC-1:0]        src_startofpacket,
   input  logic [NUM_SRC-1:0]        src_endofpacket,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [4:0]                out_empty,
   output logic                      out_startofpacket,
   output logic                      out_endofpacket,
   output logic [7:0]                out_channel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic [7:0]                drop_count
);

   // Grant index width covers the full legal range of 2..8 sources.
   localparam int unsigned GW = 3;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]         state, state_d;
   logic [GW-1:0]      grant, grant_d;
   logic [GW-1:0]      last_grant, last_grant_d;
   logic [7:0]         drop_d;

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] orphan;
   logic [NUM_SRC-1:0] grant_oh;
   logic               win_found;
   logic [GW-1:0]      win_idx;
   logic [3:0]         n_orphan;
   logic [8:0]         drop_sum;

   logic [DATA_W-1:0]  sel_data;
   logic [4:0]         sel_empty;
   logic               sel_sop;
   logic               sel_eop;
   logic               sel_valid;
   logic               can_load;
   logic               accept;

   // Round-robin winner search starting one past the last grant.
   always_comb begin
      int unsigned        idx;
      logic [NUM_SRC-1:0] shifted;
      req       = src_valid & src_startofpacket;
      orphan    = src_valid & ~src_startofpacket;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      shifted   = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         shifted = req >> idx;
         if (!win_found && shifted[0]) begin
            win_found = 1'b1;
            win_idx   = idx[GW-1:0];
         end
      end
   end

   // Orphan beat count for this cycle and the saturated drop counter value.
   always_comb begin
      n_orphan = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         n_orphan = n_orphan + {3'b000, orphan[i]};
      end
      drop_sum = {1'b0, drop_count} + {5'b00000, n_orphan};
   end

   // Multiplex the granted source's beat.
   always_comb begin
      sel_data  = '0;
      sel_empty = '0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == GW'(i)) begin
            sel_data  = src_data[i*DATA_W +: DATA_W];
            sel_empty = src_empty[i*5 +: 5];
            sel_sop   = src_startofpacket[i];
            sel_eop   = src_endofpacket[i];
            sel_valid = src_valid[i];
         end
      end
   end

   assign grant_oh = NUM_SRC'(1) << grant;
   assign can_load = !out_valid || out_ready;
   assign busy     = (state == LOCK);

   // Next-state, ready generation and drop accounting.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      drop_d       = drop_count;
      src_ready    = '0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            // Orphans are swallowed; a winner is only accepted once locked.
            src_ready = orphan;
            drop_d    = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            if (win_found) begin
               state_d      = LOCK;
               grant_d      = win_idx;
               last_grant_d = win_idx;
            end
         end
         LOCK: begin
            src_ready = can_load ? grant_oh : '0;
            accept    = sel_valid && can_load;
            if (accept && sel_eop) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (reset) begin
         src_ready = '0;
         accept    = 1'b0;
      end
   end

   // Arbitration state and drop counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GW'(NUM_SRC - 1);
         drop_count <= '0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
         drop_count <= drop_d;
      end
   end

   // Output register: load on accept, clear valid once consumed, else hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid         <= 1'b0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_data          <= '0;
         out_empty         <= '0;
         out_channel       <= '0;
      end else if (accept) begin
         out_valid         <= 1'b1;
         out_startofpacket <= sel_sop;
         out_endofpacket   <= sel_eop;
         out_data          <= sel_data;
         out_empty         <= sel_empty;
         out_channel       <= {{(8 - GW){1'b0}}, grant};
      end else if (out_ready) begin
         out_valid         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Self-checking bench for tlp_tx_arbiter: directed framing/reset/orphan cases plus a
// randomized multi-source run checked against a packet-level scoreboard.
module tb_tlp_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*DW-1:0] src_data;
   logic [N*5-1:0]  src_empty;
   logic [N-1:0]    src_startofpacket;
   logic [N-1:0]    src_endofpacket;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [DW-1:0]   out_data;
   logic [4:0]      out_empty;
   logic            out_startofpacket;
   logic            out_endofpacket;
   logic [7:0]      out_channel;
   logic            out_valid;
   logic            out_ready;
   logic            busy;
   logic [7:0]      drop_count;

   tlp_tx_arbiter #(
      .NUM_SRC(N),
      .DATA_W (DW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .src_data         (src_data),
      .src_empty        (src_empty),
      .src_startofpacket(src_startofpacket),
      .src_endofpacket  (src_endofpacket),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .out_data         (out_data),
      .out_empty        (out_empty),
      .out_startofpacket(out_startofpacket),
      .out_endofpacket  (out_endofpacket),
      .out_channel      (out_channel),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .busy             (busy),
      .drop_count       (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [4:0]    e;
      logic          sop;
      logic          eop;
      logic [7:0]    ch;
   } beat_t;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand256();
      logic [DW-1:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic clear_src();
      src_valid         = '0;
      src_startofpacket = '0;
      src_endofpacket   = '0;
      src_data          = '0;
      src_empty         = '0;
   endtask

   task automatic set_beat(input int s, input logic [DW-1:0] d, input logic [4:0] e,
                           input logic sop, input logic eop, input logic v);
      src_data[s*DW +: DW]  = d;
      src_empty[s*5 +: 5]   = e;
      src_startofpacket[s]  = sop;
      src_endofpacket[s]    = eop;
      src_valid[s]          = v;
   endtask

   // Leaves the caller at a negedge with reset just released; state is fresh.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_src();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Scoreboard and generator state for the random run.
   beat_t         q[$];
   int            gen_beat[N];
   int            gen_len[N];
   logic [DW-1:0] gen_data[N];
   logic [4:0]    gen_empty[N];

   task automatic new_packet(input int s);
      gen_beat[s]  = 0;
      gen_len[s]   = $urandom_range(1, 4);
      gen_data[s]  = rand256();
      gen_empty[s] = 5'($urandom_range(0, 31));
   endtask

   initial begin
      logic [DW-1:0] d0, d2, da, db, prev_data, pend_data;
      logic [3:0]    v;
      logic [N-1:0]  hs;
      int            cnt, exp_ch, pkts_done, pend_ch;
      bit            prev_stall, pend_chk, in_pkt;
      beat_t         b;

      reset = 1'b1;
      out_ready = 1'b0;
      clear_src();

      // Reset state, with orphans driven to show ready stays low during reset.
      src_valid = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_src_ready", 256'(src_ready), 256'(0));
      check_eq("rst_out_valid", 256'(out_valid), 256'(0));
      check_eq("rst_sop", 256'(out_startofpacket), 256'(0));
      check_eq("rst_eop", 256'(out_endofpacket), 256'(0));
      check_eq("rst_data", 256'(out_data), 256'(0));
      check_eq("rst_empty", 256'(out_empty), 256'(0));
      check_eq("rst_channel", 256'(out_channel), 256'(0));
      check_eq("rst_drop", 256'(drop_count), 256'(0));
      check_eq("rst_busy", 256'(busy), 256'(0));

      // Two single-beat packets from sources 0 and 2.
      d0 = rand256();
      d2 = rand256();
      @(negedge clk);
      reset = 1'b0;
      clear_src();
      out_ready = 1'b1;
      set_beat(0, d0, 5'd0, 1'b1, 1'b1, 1'b1);
      set_beat(2, d2, 5'd3, 1'b1, 1'b1, 1'b1);
      #1;
      check_eq("arb_cycle_ready", 256'(src_ready), 256'(0));
      @(negedge clk); #1;
      check_eq("p0_ready", 256'(src_ready), 256'(4'b0001));
      check_eq("p0_busy", 256'(busy), 256'(1));
      @(negedge clk);
      src_valid[0] = 1'b0;
      #1;
      check_eq("p0_out_valid", 256'(out_valid), 256'(1));
      check_eq("p0_channel", 256'(out_channel), 256'(0));
      check_eq("p0_data", 256'(out_data), 256'(d0));
      check_eq("gap_ready", 256'(src_ready), 256'(0));
      check_eq("gap_busy", 256'(busy), 256'(0));
      @(negedge clk); #1;
      check_eq("p2_ready", 256'(src_ready), 256'(4'b0100));
      check_eq("gap_out_valid", 256'(out_valid), 256'(0));
      @(negedge clk);
      src_valid[2] = 1'b0;
      #1;
      check_eq("p2_out_valid", 256'(out_valid), 256'(1));
      check_eq("p2_channel", 256'(out_channel), 256'(2));
      check_eq("p2_data", 256'(out_data), 256'(d2));
      check_eq("p2_sop_eop", 256'({out_startofpacket, out_endofpacket}), 256'(2'b11));

      // Orphan drops: random patterns, then source 1 long enough to saturate.
      do_reset();
      cnt = 0;
      for (int c = 0; c < 340; c++) begin
         if (c != 0) @(negedge clk);
         v = (c < 40) ? 4'($urandom_range(0, 15)) : 4'b0010;
         src_valid = v;
         src_startofpacket = '0;
         #1;
         check_eq("drop_count", 256'(drop_count), 256'(cnt));
         check_eq("orphan_ready", 256'(src_ready), 256'(v));
         check_eq("orphan_out_valid", 256'(out_valid), 256'(0));
         cnt = cnt + $countones(v);
         if (cnt > 255) cnt = 255;
      end
      @(negedge clk);
      clear_src();
      #1;
      check_eq("drop_saturated", 256'(drop_count), 256'(255));

      // Reset on the second beat of a packet aborts the grant.
      do_reset();
      set_beat(3, '0, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      @(negedge clk);
      clear_src();
      set_beat(1, rand256(), 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      check_eq("pre_rst_drop", 256'(drop_count), 256'(1));
      @(negedge clk); #1;
      check_eq("pre_rst_ready", 256'(src_ready), 256'(4'b0010));
      @(negedge clk);
      set_beat(1, rand256(), 5'd0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      @(negedge clk);
      reset = 1'b0;
      clear_src();
      set_beat(0, d0, 5'd0, 1'b1, 1'b1, 1'b1);
      set_beat(1, d2, 5'd0, 1'b1, 1'b1, 1'b1);
      #1;
      check_eq("mid_rst_out_valid", 256'(out_valid), 256'(0));
      check_eq("mid_rst_busy", 256'(busy), 256'(0));
      check_eq("mid_rst_drop", 256'(drop_count), 256'(0));
      @(negedge clk); #1;
      check_eq("post_rst_grant", 256'(src_ready), 256'(4'b0001));
      @(negedge clk);
      src_valid[0] = 1'b0;
      #1;
      check_eq("post_rst_channel", 256'(out_channel), 256'(0));
      check_eq("post_rst_valid", 256'(out_valid), 256'(1));

      // Source 3 two-beat packet with empty=0x14 on the EOP beat.
      do_reset();
      da = rand256();
      db = rand256();
      set_beat(3, da, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      @(negedge clk); #1;
      check_eq("s3_b0_ready", 256'(src_ready), 256'(4'b1000));
      @(negedge clk);
      set_beat(3, db, 5'h14, 1'b0, 1'b1, 1'b1);
      #1;
      check_eq("s3_b1_ready", 256'(src_ready), 256'(4'b1000));
      @(negedge clk);
      clear_src();
      #1;
      check_eq("s3_empty", 256'(out_empty), 256'(5'h14));
      check_eq("s3_channel", 256'(out_channel), 256'(8'h03));
      check_eq("s3_data", 256'(out_data), 256'(db));
      check_eq("s3_eop", 256'(out_endofpacket), 256'(1));

      // Random run: all sources always have a packet waiting, so grants rotate strictly.
      do_reset();
      for (int s = 0; s < N; s++) new_packet(s);
      exp_ch = 0;
      pkts_done = 0;
      prev_stall = 1'b0;
      pend_chk = 1'b0;
      pend_ch = 0;
      pend_data = '0;
      prev_data = '0;
      in_pkt = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (c != 0) @(negedge clk);
         out_ready = ($urandom_range(0, 9) < 6);
         for (int s = 0; s < N; s++) begin
            set_beat(s, gen_data[s],
                     (gen_beat[s] == gen_len[s] - 1) ? gen_empty[s] : 5'd0,
                     gen_beat[s] == 0, gen_beat[s] == gen_len[s] - 1,
                     (gen_beat[s] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
         end
         #1;
         if (prev_stall) begin
            check_eq("hold_valid", 256'(out_valid), 256'(1));
            check_eq("hold_data", 256'(out_data), 256'(prev_data));
         end
         if (pend_chk) begin
            check_eq("lat_valid", 256'(out_valid), 256'(1));
            check_eq("lat_data", 256'(out_data), 256'(pend_data));
            check_eq("lat_channel", 256'(out_channel), 256'(pend_ch));
         end
         if (out_valid && !out_ready) begin
            check_eq("stall_ready", 256'(src_ready), 256'(0));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check_eq("unexpected_beat", 256'(out_valid), 256'(0));
            end else begin
               b = q.pop_front();
               check_eq("sb_data", 256'(out_data), 256'(b.d));
               check_eq("sb_empty", 256'(out_empty), 256'(b.e));
               check_eq("sb_channel", 256'(out_channel), 256'(b.ch));
               check_eq("sb_sop_eop", 256'({out_startofpacket, out_endofpacket}),
                        256'({b.sop, b.eop}));
               if (out_startofpacket) begin
                  check_eq("rr_order", 256'(out_channel), 256'(exp_ch));
                  check_eq("framing", 256'(in_pkt), 256'(0));
                  exp_ch = (int'(out_channel) + 1) % N;
                  in_pkt = 1'b1;
               end
               if (out_endofpacket) begin
                  in_pkt = 1'b0;
                  pkts_done++;
               end
            end
         end
         hs = src_valid & src_ready;
         check_eq("one_handshake", 256'($countones(hs) <= 1), 256'(1));
         pend_chk = 1'b0;
         for (int s = 0; s < N; s++) begin
            if (hs[s]) begin
               b.d   = gen_data[s];
               b.e   = src_empty[s*5 +: 5];
               b.sop = (gen_beat[s] == 0);
               b.eop = (gen_beat[s] == gen_len[s] - 1);
               b.ch  = 8'(s);
               q.push_back(b);
               check_eq("hs_busy", 256'(busy), 256'(1));
               pend_chk  = 1'b1;
               pend_data = gen_data[s];
               pend_ch   = s;
               if (b.eop) begin
                  new_packet(s);
               end else begin
                  gen_beat[s]++;
                  gen_data[s] = rand256();
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      check_eq("progress", 256'(pkts_done >= 40), 256'(1));

      @(negedge clk);
      clear_src();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
